// File: rtl/ppu_ctrl_pkg.sv
// Shared types and constants for the PPU sequencer (ppu_ctrl and ppu_out_packer).
package ppu_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int SCALE_W        = 12;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // A zero divisor is replaced by 1 so the PPU never divides by zero.
    function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] s);
        return (s == '0) ? SCALE_W'(1) : s;
    endfunction

endpackage

// File: rtl/ppu_ctrl_if.sv
// Bus bundle between ppu_ctrl and its neighbours: psum buffer read port, PPU, output buffer write port.
interface ppu_ctrl_if
    import ppu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();

    logic                          src_rd_en;
    logic [ADDR_W-1:0]             src_rd_addr;
    logic [DATA_W-1:0]             src_rd_data;

    logic                          ppu_en;
    logic [DATA_W-1:0]             ppu_data_in;
    logic [SCALE_W-1:0]            ppu_scale;
    logic                          ppu_valid;
    logic [7:0]                    ppu_data_out;

    logic                          dst_wr_en;
    logic [ADDR_W-1:0]             dst_wr_addr;
    logic [8*BYTES_PER_WORD-1:0]   dst_wr_data;
    logic [BYTES_PER_WORD-1:0]     dst_wr_mask;

    modport master (
        output src_rd_en, src_rd_addr, ppu_en, ppu_data_in, ppu_scale,
               dst_wr_en, dst_wr_addr, dst_wr_data, dst_wr_mask,
        input  src_rd_data, ppu_valid, ppu_data_out
    );

    modport slave (
        input  src_rd_en, src_rd_addr, ppu_en, ppu_data_in, ppu_scale,
               dst_wr_en, dst_wr_addr, dst_wr_data, dst_wr_mask,
        output src_rd_data, ppu_valid, ppu_data_out
    );

endinterface

// File: rtl/ppu_out_packer.sv
// Packs PPU result bytes little-endian into 32-bit words; flushes on a full word or the last element.
module ppu_out_packer
    import ppu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        active,
    input  logic [LEN_W-1:0]            len,
    input  logic [ADDR_W-1:0]           dst_base,
    input  logic                        valid,
    input  logic [7:0]                  data,
    output logic                        wr_en,
    output logic                        wr_last,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [8*BYTES_PER_WORD-1:0] wr_data,
    output logic [BYTES_PER_WORD-1:0]   wr_mask
);

    localparam int BSEL_W = $clog2(BYTES_PER_WORD);

    logic [LEN_W-1:0]            elem_cnt;
    logic [8*BYTES_PER_WORD-1:0] pack_q, merged;
    logic [BYTES_PER_WORD-1:0]   mask;
    logic [BSEL_W-1:0]           byte_sel;
    logic                        last, flush;

    assign byte_sel = elem_cnt[BSEL_W-1:0];
    assign last     = (elem_cnt == len - 1'b1);
    assign flush    = (byte_sel == BSEL_W'(BYTES_PER_WORD - 1)) || last;

    // Mask covers bytes 0..byte_sel, which is all four for a full word.
    always_comb begin
        merged = pack_q;
        mask   = '0;
        merged[8*byte_sel +: 8] = data;
        for (int b = 0; b < BYTES_PER_WORD; b++)
            mask[b] = (b <= int'(byte_sel));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt <= '0;
            pack_q   <= '0;
            wr_en    <= 1'b0;
            wr_last  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
        end else begin
            wr_en   <= 1'b0;
            wr_last <= 1'b0;
            if (clear) begin
                elem_cnt <= '0;
                pack_q   <= '0;
            end else if (active && valid) begin
                elem_cnt <= elem_cnt + 1'b1;
                if (flush) begin
                    wr_en   <= 1'b1;
                    wr_last <= last;
                    wr_addr <= dst_base + ADDR_W'(elem_cnt >> BSEL_W);
                    wr_data <= merged;
                    wr_mask <= mask;
                    pack_q  <= '0;
                end else begin
                    pack_q  <= merged;
                end
            end
        end
    end

endmodule

// File: rtl/ppu_ctrl.sv
// PPU sequencer: streams psums into the PPU and packs its byte results into the output buffer.
// Optional PPU_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module ppu_ctrl
    import ppu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [ADDR_W-1:0]  cfg_src_base,
    input  logic [ADDR_W-1:0]  cfg_dst_base,
    input  logic [SCALE_W-1:0] cfg_scale,
    output logic               busy,
    output logic               done,
    ppu_ctrl_if.master         bus
`ifdef PPU_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    state_t             state, nstate;
    logic [LEN_W-1:0]   len_q, rd_cnt;
    logic [ADDR_W-1:0]  src_base_q, dst_base_q;
    logic [SCALE_W-1:0] scale_q;
    logic [DATA_W-1:0]  rd_data;
    logic               ppu_en_q, start_acc, last_rd;
    logic               wr_en, wr_last;
    logic [ADDR_W-1:0]  wr_addr;
    logic [8*BYTES_PER_WORD-1:0] wr_data;
    logic [BYTES_PER_WORD-1:0]   wr_mask;

    assign start_acc = start && (state == IDLE);
    assign last_rd   = (rd_cnt == len_q - 1'b1);
    assign rd_data   = bus.src_rd_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            IDLE:  if (start) nstate = (cfg_len == '0) ? DONE : READ;
            READ:  begin busy = 1'b1; if (last_rd) nstate = DRAIN; end
            DRAIN: begin busy = 1'b1; if (wr_en && wr_last) nstate = DONE; end
            DONE:  begin done = 1'b1; nstate = IDLE; end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            scale_q    <= '0;
            rd_cnt     <= '0;
            ppu_en_q   <= 1'b0;
        end else begin
            ppu_en_q <= (state == READ);
            if (start_acc) begin
                len_q      <= cfg_len;
                src_base_q <= cfg_src_base;
                dst_base_q <= cfg_dst_base;
                scale_q    <= clamp_scale(cfg_scale);
                rd_cnt     <= '0;
            end else if (state == READ) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Buffer read data is already registered, so it lines up with the one-cycle-delayed strobe.
    assign bus.src_rd_en   = (state == READ);
    assign bus.src_rd_addr = src_base_q + ADDR_W'(rd_cnt);
    assign bus.ppu_en      = ppu_en_q;
    assign bus.ppu_data_in = ppu_en_q ? rd_data : '0;
    assign bus.ppu_scale   = scale_q;

    // Gating on busy drops PPU results still in flight from an aborted run.
    ppu_out_packer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_acc),
        .active   (busy),
        .len      (len_q),
        .dst_base (dst_base_q),
        .valid    (bus.ppu_valid),
        .data     (bus.ppu_data_out),
        .wr_en    (wr_en),
        .wr_last  (wr_last),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask)
    );

    assign bus.dst_wr_en   = wr_en;
    assign bus.dst_wr_addr = wr_addr;
    assign bus.dst_wr_data = wr_data;
    assign bus.dst_wr_mask = wr_mask;

`ifdef PPU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)                            perf_cycles <= '0;
        else if (start_acc)                 perf_cycles <= '0;
        else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_ppu_ctrl.sv
// Self-checking bench for ppu_ctrl: psum buffer and PPU models plus a list-based reference of expected writes.
module tb_ppu_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] cfg_len, cfg_src_base, cfg_dst_base;
    logic [11:0] cfg_scale;
    logic        busy, done;
`ifdef PPU_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] src_mem [0:65535];
    logic [31:0] psq [$];
    logic [31:0] first_wr_data;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    ppu_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    ppu_ctrl #(.ADDR_W(16), .LEN_W(16), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_scale    (cfg_scale),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
`ifdef PPU_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Psum buffer: synchronous read, data one cycle after the strobe.
    always @(posedge clk) if (bus.src_rd_en) bus.src_rd_data <= src_mem[bus.src_rd_addr];

    // External PPU: one-cycle latency, divides by whatever scale it is given.
    function automatic logic [7:0] ppu_model(input logic [31:0] d, input logic [11:0] s);
        if (s == 12'd0) return 8'hEE;
        if (d[31])      return 8'h00;
        return 8'(d / {20'd0, s});
    endfunction

    always @(posedge clk) begin
        bus.ppu_valid    <= bus.ppu_en;
        bus.ppu_data_out <= ppu_model(bus.ppu_data_in, bus.ppu_scale);
    end

    // Reference: ReLU, divide by max(scale,1), keep low 8 bits.
    function automatic logic [7:0] ref_byte(input logic [31:0] p, input logic [11:0] sc);
        longint q;
        if ($signed(p) < 0) return 8'h00;
        q = longint'(p) / longint'((sc == 12'd0) ? 12'd1 : sc);
        return q[7:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_ctl"}, {59'd0, busy, done, bus.src_rd_en, bus.ppu_en, bus.dst_wr_en}, 64'd0);
        chk({tag, "_addr"}, {32'd0, bus.src_rd_addr, bus.dst_wr_addr}, 64'd0);
        chk({tag, "_data"}, {bus.ppu_data_in, bus.dst_wr_data}, 64'd0);
        chk({tag, "_misc"}, {48'd0, bus.ppu_scale, bus.dst_wr_mask}, 64'd0);
    endtask

    // Runs one operation over psq; poke>0 pulses a junk start at T+poke.
    task automatic run_op(input int n, input logic [15:0] sb, input logic [15:0] db,
                          input logic [11:0] sc, input int poke);
        wr_t expq [$];
        wr_t e;
        int  t0, nrd, nwr, nexp, last_wr, done_c;
        for (int i = 0; i < n; i++) src_mem[16'(sb + i)] = psq[i];
        for (int w = 0; w < (n + 3) / 4; w++) begin
            e.addr = 16'(db + w);
            e.data = '0;
            e.mask = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.data[8*b +: 8] = ref_byte(psq[4*w+b], sc);
                    e.mask[b] = 1'b1;
                end
            end
            expq.push_back(e);
        end
        nexp = expq.size();
        @(negedge clk);
        start = 1'b1; cfg_len = 16'(n); cfg_src_base = sb; cfg_dst_base = db; cfg_scale = sc;
        t0 = cyc;
        done_c = -1; last_wr = -1; nrd = 0; nwr = 0;
        for (int k = 0; k < n + 20 && done_c < 0; k++) begin
            @(negedge clk);
            start = (poke > 0) && (cyc == t0 + poke);
            if (start) begin
                cfg_len = 16'd2; cfg_src_base = 16'h5555; cfg_dst_base = 16'h6666; cfg_scale = 12'd3;
            end
            if (cyc == t0 + 1) chk("scale", bus.ppu_scale, (sc == 12'd0) ? 12'd1 : sc);
            chk("busy", busy, (n > 0) && (cyc <= t0 + n + 3));
            if (bus.src_rd_en) begin
                chk("rd_addr", bus.src_rd_addr, 16'(sb + nrd));
                chk("rd_cyc", cyc, t0 + 1 + nrd);
                nrd++;
            end
            if (bus.dst_wr_en) begin
                if (nwr == 0) first_wr_data = bus.dst_wr_data;
                if (expq.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("wr_addr", bus.dst_wr_addr, e.addr);
                    chk("wr_data", bus.dst_wr_data, e.data);
                    chk("wr_mask", bus.dst_wr_mask, e.mask);
                end
                nwr++;
                last_wr = cyc;
            end
            if (done) done_c = cyc;
        end
        start = 1'b0;
        chk("done_seen", done_c >= 0, 1);
        chk("n_rd", nrd, n);
        chk("n_wr", nwr, nexp);
        chk("done_cyc", done_c, (n == 0) ? t0 + 1 : t0 + n + 4);
        if (n > 0) chk("last_wr_cyc", last_wr, t0 + n + 3);
`ifdef PPU_CTRL_PERF_EN
        chk("perf", perf_cycles, (n == 0) ? 0 : n + 3);
`endif
        @(negedge clk);
        chk("post_idle", {busy, done, bus.src_rd_en, bus.dst_wr_en}, 4'b0000);
    endtask

    task automatic reset_midrun();
        int t0, noisy;
        psq.delete();
        for (int i = 0; i < 8; i++) psq.push_back(32'(3 * i + 1));
        for (int i = 0; i < 8; i++) src_mem[16'(16'h0200 + i)] = psq[i];
        @(negedge clk);
        start = 1'b1; cfg_len = 16'd8; cfg_src_base = 16'h0200; cfg_dst_base = 16'h0300; cfg_scale = 12'd1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && cyc < t0 + 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs_zero("midrst");
        rst = 1'b0;
        noisy = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.src_rd_en || bus.dst_wr_en || done || busy) noisy++;
        end
        chk("rst_quiet", noisy, 0);
    endtask

    initial begin
        int n;
        logic [15:0] sb, db;
        logic [11:0] sc;
        rst = 1'b1; start = 1'b0;
        cfg_len = '0; cfg_src_base = '0; cfg_dst_base = '0; cfg_scale = '0;
        repeat (3) @(negedge clk);
        outs_zero("reset");
        rst = 1'b0;

        psq = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_op(4, 16'h0010, 16'h0080, 12'd2, 0);
        chk("basic_word", first_wr_data, 32'h140F0A05);

        psq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        run_op(6, 16'h0020, 16'h0090, 12'd1, 0);

        psq = '{32'hFFFF_FFFB, 32'd300, 32'h7FFF_FFFF, 32'd0};
        run_op(4, 16'h0030, 16'h00A0, 12'd1, 0);
        chk("relu_word", first_wr_data, 32'h00FF2C00);

        psq = '{32'd7};
        run_op(1, 16'h0040, 16'h00B0, 12'd0, 0);
        chk("clamp_word", first_wr_data, 32'h00000007);

        psq.delete();
        run_op(0, 16'h0050, 16'h00C0, 12'd4, 0);

        psq.delete();
        for (int i = 0; i < 8; i++) psq.push_back(32'(10 * i + 5));
        run_op(8, 16'h0060, 16'h00D0, 12'd5, 3);

        reset_midrun();

        psq = '{32'd9, 32'd18, 32'd27, 32'd36, 32'd45};
        run_op(5, 16'h0070, 16'h00E0, 12'd9, 0);

        for (int r = 0; r < 10; r++) begin
            n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 13));
            sb = (r % 3 == 0) ? 16'hFFFC : 16'($urandom);
            db = (r % 4 == 1) ? 16'hFFFF : 16'($urandom);
            sc = 12'($urandom_range(0, 9));
            psq.delete();
            for (int i = 0; i < n; i++)
                psq.push_back(($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4000)) - 32'd1000
                                                          : 32'($urandom));
            run_op(n, sb, db, sc, (r % 2 == 0 && n > 4) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
